// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch with credit-limited requests, in-order buffer and redirect flush
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  logic [31:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem [FIFO_DEPTH];
  logic gnt, rv, push, pop;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr = fetch_pc & 32'hFFFF_FFFC;
  // credits cover buffered plus in-flight words so every kept response has a slot
  assign imem_req = rst && !redirect_valid && (({1'b0, outstanding} + {1'b0, count}) < SW'(FIFO_DEPTH));
  assign instr_valid = count != '0;
  assign instr = data_mem[rd_ptr];
  assign instr_pc = pc_mem[rd_ptr];
  assign gnt = imem_req && imem_gnt;
  assign rv = imem_rvalid && outstanding != '0;
  assign push = rv && drop_cnt == '0 && !redirect_valid;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(gnt) - CW'(rv);
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc <= target;
        drop_cnt <= outstanding - CW'(rv);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (gnt) fetch_pc <= fetch_pc + 32'd4;
        if (rv && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          data_mem[wr_ptr] <= imem_rdata;
          pc_mem[wr_ptr] <= resp_pc;
          wr_ptr <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random memory/decode/redirect stimulus against an in-order PC stream model
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FIFO_DEPTH = 2;
  logic clk = 0, rst = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, redirect_valid = 0, instr_valid, instr_ready = 0;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, instr, instr_pc;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int n_chk = 0, n_pass = 0, cyc = 0, n_acc = 0;
  logic [31:0] exp_pc, exp_fetch, h_instr, h_pc;
  logic hold_chk = 0, flush_chk = 0;
  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; instr_ready = 0;
    @(negedge clk);
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    pend.delete();
    exp_pc = RESET_PC; exp_fetch = RESET_PC;
    hold_chk = 0; flush_chk = 0;
    rst = 1;
  endtask
  task automatic step(input int gp, input int lmax, input int rp, input int dp,
                      input logic force_r, input logic [31:0] fpc);
    logic [31:0] tgt;
    @(negedge clk);
    imem_rvalid = pend.size() > 0 && pend[0].due <= cyc;
    imem_rdata = imem_rvalid ? word_at(pend[0].addr) : $urandom;
    imem_gnt = $urandom_range(99) < gp;
    instr_ready = $urandom_range(99) < rp;
    redirect_valid = force_r || ($urandom_range(99) < dp);
    tgt = force_r ? fpc : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom);
    redirect_pc = tgt;
    #1;
    if (flush_chk) check("flush", instr_valid, 0);
    if (hold_chk) begin
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, h_instr);
      check("hold_pc", instr_pc, h_pc);
    end
    if (redirect_valid) check("redir_req", imem_req, 0);
    if (imem_req && imem_gnt) begin
      check("addr", imem_addr, exp_fetch);
      pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lmax, 1))});
      exp_fetch += 4;
      check("credit", pend.size() <= FIFO_DEPTH, 1);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      check("pc", instr_pc, exp_pc);
      check("data", instr, word_at(exp_pc));
      exp_pc += 4;
      n_acc++;
    end
    hold_chk = instr_valid && !instr_ready && !redirect_valid;
    h_instr = instr; h_pc = instr_pc;
    flush_chk = redirect_valid;
    if (redirect_valid) begin
      exp_pc = {tgt[31:2], 2'b00};
      exp_fetch = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    if (imem_rvalid) void'(pend.pop_front());
    cyc++;
  endtask
  initial begin
    do_reset();
    n_acc = 0;
    repeat (20) step(100, 1, 100, 0, 0, 0);
    check("throughput", n_acc >= 10, 1);
    repeat (10) step(100, 1, 0, 0, 0, 0);
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0;
    #1;
    check("stall_req", imem_req, 0);
    check("stall_valid", instr_valid, 1);
    check("stall_pc", instr_pc, exp_pc);
    repeat (10) step(100, 1, 100, 0, 0, 0);
    repeat (4) step(100, 3, 0, 0, 0, 0);
    step(100, 2, 100, 0, 1, 32'h0000_0100);
    repeat (15) step(100, 2, 100, 0, 0, 0);
    step(100, 1, 100, 0, 1, 32'hFFFF_FFFE);
    n_acc = 0;
    repeat (12) step(100, 1, 100, 0, 0, 0);
    check("wrap_progress", n_acc >= 4, 1);
    repeat (800) step(70, 3, 70, 8, 0, 0);
    repeat (300) step(90, 1, 90, 15, 0, 0);
    repeat (8) step(100, 2, 0, 0, 0, 0);
    do_reset();
    n_acc = 0;
    repeat (20) step(100, 2, 100, 0, 0, 0);
    check("post_reset_progress", n_acc >= 5, 1);
    repeat (300) step(60, 3, 50, 5, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end. It owns the architectural fetch PC and issues sequential word requests to instruction memory over a req/gnt/rvalid protocol.
- Returned words are buffered with their PCs in a small in-order FIFO and handed to decode over a valid/ready interface.
- Branch/jump redirects from execute restart fetch at a new PC and discard every stale in-flight response.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, minimum 2; also the cap on outstanding requests.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch.
- redirect_pc  in  32  new fetch target.
- instr_valid  out  1  decode output valid.
- instr_ready  in  1  decode accepts.
- instr  out  32  instruction word at the FIFO head.
- instr_pc  out  32  PC of instr.

Behaviour:
- All state updates on posedge clk.
- rst==0 sets: fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty. Outputs after reset: imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- imem_addr = {fetch_pc[31:2],2'b00}.
- imem_req = !redirect_valid && (outstanding + fifo_count < FIFO_DEPTH). This credit rule guarantees every non-dropped response has a FIFO slot.
- Request handshake: imem_req && imem_gnt -> fetch_pc += 4 (mod 2^32, wraps at 32'hFFFFFFFC -> 0) and outstanding += 1.
- Memory must tolerate a request withdrawn before gnt. Address is stable while req stays high.
- Response handling, imem_rvalid=1: outstanding -= 1.
  - drop_cnt>0: discard the data, drop_cnt -= 1.
  - Otherwise: push {imem_rdata, resp_pc}, then resp_pc += 4.
- Same-cycle gnt and rvalid: outstanding unchanged.
- Output side:
  - instr_valid = FIFO non-empty.
  - instr and instr_pc show the head entry, taken directly from FIFO storage; they hold their value while instr_valid && !instr_ready.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full, and leave fifo_count unchanged.
- Latency: gnt at cycle N, rvalid at N+k -> instr_valid at N+k+1 if the FIFO was empty.
- Redirect (redirect_valid=1), highest priority:
  - fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}; bits [1:0] are ignored.
  - FIFO flushed; any pop that cycle is ignored.
  - imem_req forced 0, so no gnt can complete that cycle.
  - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0); a response arriving in the redirect cycle is always discarded.
  - outstanding updates normally.
  - instr_valid=0 the next cycle.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding. The last target wins.
- Consistency invariants:
  - imem_rvalid with outstanding==0 is a protocol error; the unit ignores it and no counter underflows.
  - drop_cnt <= outstanding <= FIFO_DEPTH at all times.
- Reset asserted mid-operation clears everything in one cycle. Pending responses are not tracked; memory is reset with the core.

Test Plan:
- Reset, then gnt always 1 with 1-cycle rvalid, instr_ready=1 -> imem_addr 0,4,8,...; instr_pc 0,4,8 with matching rdata; sustained one instruction per cycle.
- instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests granted, then imem_req=0; FIFO holds PCs 0 and 4 stable; ready=1 -> requests resume at addr 8.
- Two requests outstanding (addr 8, 12), redirect_pc=32'h100 -> both responses dropped; next instr_pc=32'h100; imem_req=0 during the redirect cycle.
- Redirect in the same cycle as rvalid for addr 4, one more outstanding -> that response and the next are dropped; drop_cnt=1 after the redirect.
- redirect_pc=32'hFFFFFFFE -> fetch 32'hFFFFFFFC, then 32'h00000000 (wrap); instr_pc values match.
- rst=0 asserted with outstanding=2 and FIFO full -> next cycle imem_req=0, instr_valid=0, imem_addr=RESET_PC; fetch restarts cleanly.
